// File: rtl/axil_mbox_regbank.sv
// axil_mbox_regbank: AXI-Lite mailbox + interrupt register bank with a remote write port driving mb_irq.
// Define AXIL_MBOX_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axil_mbox_regbank #(
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_MBOX   = 8,
  parameter int IDX_WIDTH  = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  input  logic                  rm_wvalid,
  input  logic [IDX_WIDTH-1:0]  rm_widx,
  input  logic [31:0]           rm_wdata,
  input  logic [3:0]            rm_wstrb,
  input  logic                  cc_aa_enable,
  output logic                  mb_irq
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam logic [AW-1:0] A_EN  = AW'(64);
  localparam logic [AW-1:0] A_ST  = AW'(65);
  localparam logic [AW-1:0] A_MSK = AW'(66);
`ifdef AXIL_MBOX_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif
  logic                r_aw_held, r_w_held, r_bvalid, r_rvalid, r_en, r_irq;
  logic [AW-1:0]       r_aw_word;
  logic [31:0]         r_w_data, r_rdata;
  logic [3:0]          r_w_strb;
  logic [1:0]          r_bresp, r_rresp;
  logic [31:0]         r_mbox [NUM_MBOX];
  logic [NUM_MBOX-1:0] r_status, r_mask;
  logic [NUM_MBOX-1:0] w_rm_sel, w_wsel, w_clr;
  logic                w_commit, w_whit, w_rhit, w_unused;
  logic [31:0]         w_rdata;
  logic [AW-1:0]       w_rword;
  assign s_awready = cc_aa_enable & ~r_aw_held & ~r_bvalid;
  assign s_wready  = cc_aa_enable & ~r_w_held & ~r_bvalid;
  assign s_arready = cc_aa_enable & ~r_rvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;
  assign mb_irq    = r_irq;
  assign w_commit  = r_aw_held & r_w_held;
  assign w_rword   = s_araddr[ADDR_WIDTH-1:2];
  assign w_unused  = ^{s_awaddr[1:0], s_araddr[1:0]};
  // Decode by equality per mailbox so out-of-range indices simply match nothing.
  always_comb begin
    w_rdata = '0;
    w_rhit  = 1'b0;
    for (int i = 0; i < NUM_MBOX; i++) begin
      w_rm_sel[i] = rm_wvalid & (rm_widx == IDX_WIDTH'(i));
      w_wsel[i]   = r_aw_word == AW'(i);
      w_clr[i]    = w_commit & (r_aw_word == A_ST) & r_w_strb[i/8] & r_w_data[i];
      if (w_rword == AW'(i)) begin
        w_rdata = r_mbox[i];
        w_rhit  = 1'b1;
      end
    end
    w_whit = (|w_wsel) | (r_aw_word == A_EN) | (r_aw_word == A_ST) | (r_aw_word == A_MSK);
    if (w_rword == A_EN) begin
      w_rdata = {31'b0, r_en};
      w_rhit  = 1'b1;
    end else if (w_rword == A_ST) begin
      w_rdata = 32'(r_status);
      w_rhit  = 1'b1;
    end else if (w_rword == A_MSK) begin
      w_rdata = 32'(r_mask);
      w_rhit  = 1'b1;
    end
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_word <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_en      <= 1'b0;
      r_status  <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
      for (int i = 0; i < NUM_MBOX; i++) r_mbox[i] <= '0;
    end else begin
      if (s_awvalid & s_awready) begin
        r_aw_held <= 1'b1;
        r_aw_word <= s_awaddr[ADDR_WIDTH-1:2];
      end else if (w_commit) r_aw_held <= 1'b0;
      if (s_wvalid & s_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end else if (w_commit) r_w_held <= 1'b0;
      r_bvalid <= w_commit | (r_bvalid & ~s_bready);
      if (w_commit) r_bresp <= w_whit ? 2'b00 : UNMAP_RESP;
      if (s_arvalid & s_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rhit ? 2'b00 : UNMAP_RESP;
      end else if (s_rready) r_rvalid <= 1'b0;
      if (w_commit && r_aw_word == A_EN && r_w_strb[0]) r_en <= r_w_data[0];
      // Remote bytes take priority over a same-edge AXI commit.
      for (int i = 0; i < NUM_MBOX; i++) begin
        if (w_commit && r_aw_word == A_MSK && r_w_strb[i/8]) r_mask[i] <= r_w_data[i];
        for (int b = 0; b < 4; b++) begin
          if (w_rm_sel[i] & rm_wstrb[b]) r_mbox[i][8*b +: 8] <= rm_wdata[8*b +: 8];
          else if (w_commit & w_wsel[i] & r_w_strb[b]) r_mbox[i][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
      r_status <= (r_status & ~w_clr) | w_rm_sel;
      r_irq    <= r_en & |(r_status & r_mask);
    end
  end
endmodule

// File: tb/tb_axil_mbox_regbank.sv
// tb_axil_mbox_regbank: directed self-checking bench for the mailbox register bank.
module tb_axil_mbox_regbank;
`ifdef AXIL_MBOX_SLVERR_EN
  localparam logic [1:0] UNMAP = 2'b10;
`else
  localparam logic [1:0] UNMAP = 2'b00;
`endif
  logic        clk = 1'b0, rst_n;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [14:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata, rm_wdata;
  logic [3:0]  s_wstrb, rm_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        rm_wvalid, cc_aa_enable, mb_irq;
  logic [2:0]  rm_widx;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  axil_mbox_regbank dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .rm_wvalid(rm_wvalid), .rm_widx(rm_widx), .rm_wdata(rm_wdata), .rm_wstrb(rm_wstrb),
    .cc_aa_enable(cc_aa_enable), .mb_irq(mb_irq)
  );

  task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    logic aw_d, w_d, ah, wh, got;
    aw_d = 0; w_d = 0; got = 0; resp = 2'bxx;
    @(negedge clk);
    s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = d; s_wstrb = s;
    for (int n = 0; n < 50 && !(aw_d && w_d); n++) begin
      ah = s_awvalid & s_awready;
      wh = s_wvalid & s_wready;
      @(posedge clk); #1;
      if (ah) begin s_awvalid = 0; aw_d = 1; end
      if (wh) begin s_wvalid = 0; w_d = 1; end
      if (!(aw_d && w_d)) @(negedge clk);
    end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (s_bvalid) begin got = 1; resp = s_bresp; end
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!got) begin total++; bad++; $display("FAIL write_timeout addr=%h", a); end
  endtask

  task automatic axi_read(input logic [14:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic ar_d, got;
    ar_d = 0; got = 0; d = 'x; resp = 2'bxx;
    @(negedge clk);
    s_arvalid = 1; s_araddr = a;
    for (int n = 0; n < 50 && !ar_d; n++) begin
      if (s_arready) begin
        @(posedge clk); #1;
        s_arvalid = 0; ar_d = 1;
      end else @(negedge clk);
    end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (s_rvalid) begin got = 1; d = s_rdata; resp = s_rresp; end
    end
    s_arvalid = 0;
    if (!got) begin total++; bad++; $display("FAIL read_timeout addr=%h", a); end
  endtask

  task automatic remote(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    rm_wvalid = 1; rm_widx = idx; rm_wdata = d; rm_wstrb = s;
    @(posedge clk); #1;
    rm_wvalid = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    total++; if ({s_bvalid, s_rvalid, mb_irq, s_awready, s_wready, s_arready} !== 6'b0) begin bad++; $display("FAIL rst_valids got=%b want=000000", {s_bvalid, s_rvalid, mb_irq, s_awready, s_wready, s_arready}); end
    total++; if ({s_rdata, s_bresp, s_rresp} !== 36'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {s_rdata, s_bresp, s_rresp}); end
    rst_n = 1; cc_aa_enable = 1;
    axi_read(15'h100, d, r);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL rst_en got=%h/%b want=0/00", d, r); end
    axi_read(15'hC, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mbox3 got=%h want=0", d); end
  endtask

  task automatic test_enable_rw;
    logic [31:0] d; logic [1:0] r;
    axi_write(15'h100, 32'h1, 4'b0001, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL en_bresp got=%b want=00", r); end
    axi_read(15'h100, d, r);
    total++; if (d !== 32'h1 || r !== 2'b00) begin bad++; $display("FAIL en_read got=%h/%b want=1/00", d, r); end
    axi_write(15'h100, 32'hFFFFFFFE, 4'b1110, r);
    axi_read(15'h100, d, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL en_strb got=%h want=1", d); end
  endtask

  task automatic test_split_write;
    logic [31:0] d; logic [1:0] r; int pulses;
    @(negedge clk);
    s_wvalid = 1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'b0011;
    total++; if (s_wready !== 1'b1) begin bad++; $display("FAIL split_wready got=%b want=1", s_wready); end
    @(posedge clk); #1; s_wvalid = 0;
    repeat (3) @(negedge clk);
    total++; if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin bad++; $display("FAIL split_held got=%b%b want=00", s_wready, s_bvalid); end
    s_awvalid = 1; s_awaddr = 15'h8;
    @(posedge clk); #1; s_awvalid = 0;
    @(negedge clk);
    total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL split_bv_early got=%b want=0", s_bvalid); end
    @(negedge clk);
    total++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin bad++; $display("FAIL split_bv got=%b/%b want=1/00", s_bvalid, s_bresp); end
    pulses = 0;
    repeat (6) begin @(negedge clk); if (s_bvalid) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL split_extra_b got=%0d want=0", pulses); end
    axi_read(15'h8, d, r);
    total++; if (d !== 32'h0000A5A5) begin bad++; $display("FAIL split_data got=%h want=0000a5a5", d); end
  endtask

  task automatic test_remote_irq;
    logic [31:0] d; logic [1:0] r;
    axi_write(15'h108, 32'h4, 4'b0001, r);
    remote(3'd2, 32'h12345678, 4'b1111);
    @(negedge clk);
    total++; if (mb_irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", mb_irq); end
    @(negedge clk);
    total++; if (mb_irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", mb_irq); end
    axi_read(15'h8, d, r);
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL rm_data got=%h want=12345678", d); end
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL rm_status got=%h want=4", d); end
    axi_write(15'h104, 32'h4, 4'b0001, r);
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_status got=%h want=0", d); end
    total++; if (mb_irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want=0", mb_irq); end
    remote(3'd5, 32'hCAFEF00D, 4'b1111);
    repeat (3) @(negedge clk);
    total++; if (mb_irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", mb_irq); end
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL status5 got=%h want=20", d); end
    axi_write(15'h104, 32'h20, 4'b0001, r);
  endtask

  task automatic collide(input logic [14:0] a, input logic [31:0] ad, input logic [3:0] as,
                         input logic [2:0] idx, input logic [31:0] rd, input logic [3:0] rs);
    @(negedge clk);
    s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = ad; s_wstrb = as;
    total++; if ((s_awready & s_wready) !== 1'b1) begin bad++; $display("FAIL col_ready got=%b want=1", s_awready & s_wready); end
    @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0;
    remote(idx, rd, rs);
    @(negedge clk);
    total++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin bad++; $display("FAIL col_b got=%b/%b want=1/00", s_bvalid, s_bresp); end
  endtask

  task automatic test_collision;
    logic [31:0] d; logic [1:0] r;
    collide(15'h4, 32'hFFFFFFFF, 4'b1111, 3'd1, 32'h0, 4'b0011);
    axi_read(15'h4, d, r);
    total++; if (d !== 32'hFFFF0000) begin bad++; $display("FAIL col_mbox got=%h want=ffff0000", d); end
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL col_status got=%h want=2", d); end
    collide(15'h104, 32'h2, 4'b0001, 3'd1, 32'h77, 4'b0001);
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL col_w1c got=%h want=2", d); end
    axi_write(15'h104, 32'h2, 4'b0001, r);
    axi_read(15'h104, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL col_clr got=%h want=0", d); end
  endtask

  task automatic test_cc_block;
    int viol; logic done;
    @(negedge clk);
    cc_aa_enable = 0; s_arvalid = 1; s_araddr = 15'h100; viol = 0; done = 0;
    repeat (10) begin @(negedge clk); if (s_arready | s_rvalid) viol++; end
    total++; if (viol !== 0) begin bad++; $display("FAIL cc_block got=%0d want=0", viol); end
    cc_aa_enable = 1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (s_arready) begin @(posedge clk); #1; s_arvalid = 0; done = 1; end
      else @(negedge clk);
    end
    s_arvalid = 0;
    @(negedge clk);
    total++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h1) begin bad++; $display("FAIL cc_read got=%b/%h want=1/1", s_rvalid, s_rdata); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic [1:0] r;
    axi_read(15'h200, d, r);
    total++; if (d !== 32'h0 || r !== UNMAP) begin bad++; $display("FAIL unmap_rd got=%h/%b want=0/%b", d, r, UNMAP); end
    axi_write(15'h200, 32'hFFFFFFFF, 4'b1111, r);
    total++; if (r !== UNMAP) begin bad++; $display("FAIL unmap_wr got=%b want=%b", r, UNMAP); end
    axi_write(15'h20, 32'hDEADBEEF, 4'b1111, r);
    total++; if (r !== UNMAP) begin bad++; $display("FAIL unmap_mb8 got=%b want=%b", r, UNMAP); end
    axi_read(15'h20, d, r);
    total++; if (d !== 32'h0 || r !== UNMAP) begin bad++; $display("FAIL unmap_rd8 got=%h/%b want=0/%b", d, r, UNMAP); end
    axi_read(15'h1C, d, r);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL mbox7 got=%h/%b want=0/00", d, r); end
    axi_read(15'h100, d, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL unmap_side got=%h want=1", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic [1:0] r; int hs [2]; int cnt;
    cnt = 0; hs[0] = 0; hs[1] = 0;
    @(negedge clk);
    s_awvalid = 1; s_awaddr = 15'h10; s_wvalid = 1; s_wdata = 32'h11111111; s_wstrb = 4'hF;
    for (int c = 0; c < 30 && cnt < 2; c++) begin
      if (s_awready & s_wready) begin
        hs[cnt] = c; cnt++;
        @(posedge clk); #1;
        if (cnt == 1) begin s_awaddr = 15'h14; s_wdata = 32'h22222222; end
        else begin s_awvalid = 0; s_wvalid = 0; end
      end else begin @(posedge clk); #1; end
      @(negedge clk);
    end
    s_awvalid = 0; s_wvalid = 0;
    total++; if (cnt !== 2 || hs[1] - hs[0] !== 3) begin bad++; $display("FAIL b2b_rate got=%0d/%0d want=2/3", cnt, hs[1] - hs[0]); end
    repeat (3) @(negedge clk);
    axi_read(15'h10, d, r);
    total++; if (d !== 32'h11111111) begin bad++; $display("FAIL b2b_d0 got=%h want=11111111", d); end
    axi_read(15'h14, d, r);
    total++; if (d !== 32'h22222222) begin bad++; $display("FAIL b2b_d1 got=%h want=22222222", d); end
  endtask

  initial begin
    rst_n = 0; cc_aa_enable = 0; s_bready = 1; s_rready = 1;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
    s_arvalid = 0; s_araddr = 0; rm_wvalid = 0; rm_widx = 0; rm_wdata = 0; rm_wstrb = 0;
    repeat (3) @(posedge clk);
    test_reset;
    test_enable_rw;
    test_split_write;
    test_remote_irq;
    test_collision;
    test_cc_block;
    test_unmapped;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
